rn_axis_pkt_rx: RTL and testbench

RN_AXIS_PKT_RX -- requirements
Module: rn_axis_pkt_rx

---
 rtl/rn_tb_pkg.sv | 65 ++++++
 rtl/rn_desc_fifo.sv | 63 ++++++
 rtl/rn_axis_pkt_rx.sv | 195 +++++++++++++++++++
 tb/tb_rn_axis_pkt_rx.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rn_tb_pkg.sv
// -----------------------------------------------------------------------------
// rn_tb_pkg
// Shared types and helpers for the AXI-Stream packet receiver.
//   rn_rx_state_t : receiver FSM state (IDLE / RECV)
//   rn_rx_desc_t  : descriptor stored in the descriptor FIFO
//   rn_popcount   : number of set byte enables in a beat
//   rn_xor_fold   : XOR of all 32-bit lanes with disabled bytes forced to zero
//   rn_keep_contig: byte enables form a non-empty run starting at bit 0
// The helpers work on vectors padded to RN_MAX_KEEP_W bytes, so one set of
// functions serves every legal stream width up to that limit.
// -----------------------------------------------------------------------------
package rn_tb_pkg;

  localparam int RN_MAX_KEEP_W = 128;
  localparam int RN_MAX_DATA_W = RN_MAX_KEEP_W * 8;
  localparam int RN_MAX_SIZE_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rn_rx_state_t;

  // byte_cnt is held at the widest supported size; the top truncates it
  typedef struct packed {
    logic [RN_MAX_SIZE_W-1:0] byte_cnt;
    logic [15:0]              beat_cnt;
    logic                     len_err;
    logic                     keep_err;
    logic [31:0]              csum;
  } rn_rx_desc_t;

  function automatic logic [15:0] rn_popcount(input logic [RN_MAX_KEEP_W-1:0] keep);
    logic [15:0] cnt;
    cnt = 16'd0;
    for (int i = 0; i < RN_MAX_KEEP_W; i++) begin
      cnt = cnt + {15'd0, keep[i]};
    end
    return cnt;
  endfunction

  // Byte i lands in lane position i%4, so folding all lanes reduces to
  // XOR-ing each enabled byte into its position of a single 32-bit word.
  function automatic logic [31:0] rn_xor_fold(input logic [RN_MAX_DATA_W-1:0] data,
                                              input logic [RN_MAX_KEEP_W-1:0] keep);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < RN_MAX_KEEP_W; i++) begin
      if (keep[i]) begin
        acc[(i % 4) * 8 +: 8] = acc[(i % 4) * 8 +: 8] ^ data[i * 8 +: 8];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // A run of ones from bit 0 plus one is a single power of two, so the AND
  // with the original is zero; an all-zero keep is rejected explicitly.
  function automatic logic rn_keep_contig(input logic [RN_MAX_KEEP_W-1:0] keep);
    logic [RN_MAX_KEEP_W-1:0] nxt;
    nxt = keep + {{(RN_MAX_KEEP_W-1){1'b0}}, 1'b1};
    return (keep != {RN_MAX_KEEP_W{1'b0}}) && ((keep & nxt) == {RN_MAX_KEEP_W{1'b0}});
  endfunction

endpackage

// File: rtl/rn_desc_fifo.sv
// -----------------------------------------------------------------------------
// rn_desc_fifo
// Synchronous first-word-fall-through FIFO for receive descriptors.
//   clk, rst   : clock and synchronous active-high reset
//   push/data  : write request and descriptor (ignored while full)
//   pop        : read request (ignored while empty)
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : occupancy flags
// DEPTH must be a power of two and at least 2. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
// -----------------------------------------------------------------------------
module rn_desc_fifo
  import rn_tb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  rn_rx_desc_t push_data,
  input  logic        pop,
  output rn_rx_desc_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  rn_rx_desc_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle both advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/rn_axis_pkt_rx.sv
// -----------------------------------------------------------------------------
// rn_axis_pkt_rx
// AXI-Stream packet receiver: accumulates per-packet byte/beat counts, a
// masked XOR checksum and length/keep error flags, and emits one descriptor
// per packet through a FWFT descriptor FIFO.
//   axis_clk, axis_rst : clock, synchronous active-high reset
//   s_axis_*           : input stream (tuser_size = declared length in bytes)
//   bp_pattern         : 16-cycle rotating ready mask, 16'hFFFF = no throttling
//   desc_valid/ready   : descriptor handshake
//   desc_*             : head descriptor fields (zero while no descriptor)
//   pkt_cnt, err_cnt   : packets pushed / packets pushed with any error
// -----------------------------------------------------------------------------
module rn_axis_pkt_rx
  import rn_tb_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int USER_SIZE_WIDTH = 16,
  parameter int DESC_FIFO_DEPTH = 8
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [USER_SIZE_WIDTH-1:0] s_axis_tuser_size,
  output logic                       s_axis_tready,
  input  logic [15:0]                bp_pattern,
  output logic                       desc_valid,
  input  logic                       desc_ready,
  output logic [USER_SIZE_WIDTH-1:0] desc_byte_cnt,
  output logic [15:0]                desc_beat_cnt,
  output logic                       desc_len_err,
  output logic                       desc_keep_err,
  output logic [31:0]                desc_csum,
  output logic [31:0]                pkt_cnt,
  output logic [31:0]                err_cnt
);

  rn_rx_state_t               state;
  logic [3:0]                 bp_ptr;
  logic [USER_SIZE_WIDTH-1:0] size_cap;
  logic [USER_SIZE_WIDTH-1:0] byte_acc;
  logic [15:0]                beat_acc;
  logic                       len_acc;
  logic                       keep_acc;
  logic [31:0]                csum_acc;

  logic [RN_MAX_DATA_W-1:0]   data_pad;
  logic [RN_MAX_KEEP_W-1:0]   keep_pad;
  logic                       accept;
  logic                       first;
  logic                       push;
  logic [15:0]                beat_pop;
  logic                       beat_keep_ok;
  logic [USER_SIZE_WIDTH-1:0] ref_size;
  logic [USER_SIZE_WIDTH-1:0] byte_next;
  logic [15:0]                beat_next;
  logic                       len_next;
  logic                       keep_next;
  logic [31:0]                csum_next;
  logic                       final_len_err;
  rn_rx_desc_t                push_desc;

  logic                       fifo_full;
  logic                       fifo_empty;
  rn_rx_desc_t                fifo_rd_data;
  rn_rx_desc_t                head_desc;
  logic                       unused_desc_bits;

  // Widen the beat to the helper width; unused upper bytes read as disabled.
  always_comb begin
    data_pad = '0;
    keep_pad = '0;
    data_pad[AXIS_DATA_WIDTH-1:0] = s_axis_tdata;
    keep_pad[AXIS_KEEP_WIDTH-1:0] = s_axis_tkeep;
  end

  assign s_axis_tready = !axis_rst && bp_pattern[bp_ptr] && !fifo_full;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign first         = (state == ST_IDLE);
  assign push          = accept && s_axis_tlast;

  // Next-value computation for the per-packet totals, including this beat.
  // On the first beat the stale accumulators are replaced rather than added.
  always_comb begin
    beat_pop      = rn_popcount(keep_pad);
    beat_keep_ok  = s_axis_tlast ? rn_keep_contig(keep_pad)
                                 : (s_axis_tkeep == {AXIS_KEEP_WIDTH{1'b1}});
    ref_size      = first ? s_axis_tuser_size : size_cap;
    byte_next     = (first ? {USER_SIZE_WIDTH{1'b0}} : byte_acc) + USER_SIZE_WIDTH'(beat_pop);
    beat_next     = first ? 16'd1
                          : ((beat_acc == 16'hFFFF) ? 16'hFFFF : (beat_acc + 16'd1));
    len_next      = (first ? 1'b0 : len_acc) || (!first && (s_axis_tuser_size != size_cap));
    keep_next     = (first ? 1'b0 : keep_acc) || !beat_keep_ok;
    csum_next     = (first ? 32'd0 : csum_acc) ^ rn_xor_fold(data_pad, keep_pad);
    final_len_err = len_next || (byte_next != ref_size);

    push_desc          = '0;
    push_desc.byte_cnt = RN_MAX_SIZE_W'(byte_next);
    push_desc.beat_cnt = beat_next;
    push_desc.len_err  = final_len_err;
    push_desc.keep_err = keep_next;
    push_desc.csum     = csum_next;
  end

  // Receiver FSM and per-packet accumulators; a tlast beat clears them.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state    <= ST_IDLE;
      size_cap <= '0;
      byte_acc <= '0;
      beat_acc <= 16'd0;
      len_acc  <= 1'b0;
      keep_acc <= 1'b0;
      csum_acc <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !s_axis_tlast) begin
            state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (accept && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (accept) begin
        if (s_axis_tlast) begin
          size_cap <= '0;
          byte_acc <= '0;
          beat_acc <= 16'd0;
          len_acc  <= 1'b0;
          keep_acc <= 1'b0;
          csum_acc <= 32'd0;
        end else begin
          size_cap <= ref_size;
          byte_acc <= byte_next;
          beat_acc <= beat_next;
          len_acc  <= len_next;
          keep_acc <= keep_next;
          csum_acc <= csum_next;
        end
      end
    end
  end

  // Free-running backpressure pointer and packet/error statistics.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      bp_ptr  <= 4'd0;
      pkt_cnt <= 32'd0;
      err_cnt <= 32'd0;
    end else begin
      bp_ptr <= bp_ptr + 4'd1;
      if (push) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        if (final_len_err || keep_next) begin
          err_cnt <= err_cnt + 32'd1;
        end
      end
    end
  end

  rn_desc_fifo #(
    .DEPTH(DESC_FIFO_DEPTH)
  ) u_desc_fifo (
    .clk      (axis_clk),
    .rst      (axis_rst),
    .push     (push),
    .push_data(push_desc),
    .pop      (desc_valid && desc_ready),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The FIFO storage is not reset, so the head is masked while empty.
  assign head_desc        = fifo_empty ? '0 : fifo_rd_data;
  assign desc_valid       = !fifo_empty;
  assign desc_byte_cnt    = head_desc.byte_cnt[USER_SIZE_WIDTH-1:0];
  assign desc_beat_cnt    = head_desc.beat_cnt;
  assign desc_len_err     = head_desc.len_err;
  assign desc_keep_err    = head_desc.keep_err;
  assign desc_csum        = head_desc.csum;
  assign unused_desc_bits = ^head_desc.byte_cnt;

endmodule

// File: tb/tb_rn_axis_pkt_rx.sv
// -----------------------------------------------------------------------------
// tb_rn_axis_pkt_rx
// Randomised scoreboard bench: each packet is modelled from its byte list
// when issued, the expectation is queued, and a monitor compares every
// descriptor the DUT hands out.
// -----------------------------------------------------------------------------
module tb_rn_axis_pkt_rx;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int SW = 16;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [SW-1:0] s_axis_tuser_size = '0;
  logic          s_axis_tready;
  logic [15:0]   bp_pattern = 16'hFFFF;
  logic          desc_valid;
  logic          desc_ready = 1'b1;
  logic [SW-1:0] desc_byte_cnt;
  logic [15:0]   desc_beat_cnt;
  logic          desc_len_err;
  logic          desc_keep_err;
  logic [31:0]   desc_csum;
  logic [31:0]   pkt_cnt;
  logic [31:0]   err_cnt;

  rn_axis_pkt_rx dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser_size(s_axis_tuser_size), .s_axis_tready(s_axis_tready),
    .bp_pattern(bp_pattern), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_byte_cnt(desc_byte_cnt), .desc_beat_cnt(desc_beat_cnt),
    .desc_len_err(desc_len_err), .desc_keep_err(desc_keep_err),
    .desc_csum(desc_csum), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    int          bytes;
    int          beats;
    bit          len_err;
    bit          keep_err;
    logic [31:0] csum;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] pk_data[$];
  logic [KW-1:0] pk_keep[$];
  logic [SW-1:0] pk_size[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            exp_pkt = 0;
  int            exp_err = 0;
  int            n_desc = 0;
  bit            rand_ready_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i * 32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KW-1:0] ones_keep(input int n);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  task automatic clear_pk();
    pk_data.delete();
    pk_keep.delete();
    pk_size.delete();
  endtask

  task automatic add_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [SW-1:0] s);
    pk_data.push_back(d);
    pk_keep.push_back(k);
    pk_size.push_back(s);
  endtask

  // Reference model: totals from the packet's byte list.
  task automatic model_push();
    exp_t          e;
    int            tot;
    bit            seen0;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
    tot = 0;
    e.beats = 0; e.len_err = 1'b0; e.keep_err = 1'b0; e.csum = 32'd0;
    for (int b = 0; b < pk_data.size(); b++) begin
      k = pk_keep[b];
      d = pk_data[b];
      tot += $countones(k);
      if (e.beats < 65535) e.beats++;
      if (b == pk_data.size() - 1) begin
        seen0 = 1'b0;
        if (!k[0]) e.keep_err = 1'b1;
        for (int i = 0; i < KW; i++) begin
          if (!k[i]) seen0 = 1'b1;
          else if (seen0) e.keep_err = 1'b1;
        end
      end else if (k != {KW{1'b1}}) begin
        e.keep_err = 1'b1;
      end
      if (pk_size[b] != pk_size[0]) e.len_err = 1'b1;
      for (int i = 0; i < KW; i++)
        if (k[i]) e.csum[(i % 4) * 8 +: 8] = e.csum[(i % 4) * 8 +: 8] ^ d[i * 8 +: 8];
    end
    e.bytes = tot % 65536;
    if (e.bytes != int'(pk_size[0])) e.len_err = 1'b1;
    exp_q.push_back(e);
    exp_pkt++;
    if (e.len_err || e.keep_err) exp_err++;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input int idx);
    int budget;
    s_axis_tdata      = pk_data[idx];
    s_axis_tkeep      = pk_keep[idx];
    s_axis_tuser_size = pk_size[idx];
    s_axis_tlast      = (idx == pk_data.size() - 1);
    s_axis_tvalid     = 1'b1;
    #1;
    budget = 0;
    while (!s_axis_tready && budget < 2000) begin
      @(negedge axis_clk); #1;
      budget++;
    end
    if (!s_axis_tready) begin
      n_tests++; n_fail++;
      $display("FAIL beat_accept_timeout: tready got 0 expected 1 within 2000 cycles");
    end
    @(negedge axis_clk);
    s_axis_tvalid     = 1'b0;
    s_axis_tdata      = rand_data();
    s_axis_tkeep      = {$urandom, $urandom};
    s_axis_tlast      = 1'($urandom_range(0, 1));
    s_axis_tuser_size = 16'($urandom);
  endtask

  task automatic send_pkt();
    model_push();
    for (int b = 0; b < pk_data.size(); b++) send_beat(b);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || desc_valid) && budget < 5000) begin
      @(negedge axis_clk);
      budget++;
    end
    check("drain_timeout", {63'd0, (exp_q.size() != 0 || desc_valid)}, 64'd0);
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    check("err_cnt", 64'(err_cnt), 64'(exp_err));
  endtask

  task automatic build_random();
    int            nb;
    int            tot;
    int            n;
    logic [KW-1:0] ks[4];
    logic [SW-1:0] sz;
    nb  = $urandom_range(1, 4);
    tot = 0;
    for (int b = 0; b < nb; b++) begin
      if (b < nb - 1) begin
        ks[b] = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : {KW{1'b1}};
      end else begin
        n = $urandom_range(1, KW);
        ks[b] = ones_keep(n);
        if ($urandom_range(0, 7) == 0) ks[b] = {$urandom, $urandom};
      end
      tot += $countones(ks[b]);
    end
    sz = 16'(tot);
    if ($urandom_range(0, 3) == 0) sz = sz + 16'($urandom_range(1, 50));
    clear_pk();
    for (int b = 0; b < nb; b++) add_beat(rand_data(), ks[b], sz);
    if (nb > 1 && $urandom_range(0, 7) == 0) pk_size[nb - 1] = sz ^ 16'h0001;
  endtask

  // Random consumer stall when enabled.
  always @(negedge axis_clk) begin
    if (rand_ready_en) desc_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compare every handed-out descriptor with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge axis_clk); #2;
      if (!axis_rst && desc_valid && desc_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_desc: got bytes=%0d with no descriptor expected", desc_byte_cnt);
        end else begin
          e = exp_q.pop_front();
          if (int'(desc_byte_cnt) != e.bytes || int'(desc_beat_cnt) != e.beats ||
              desc_len_err != e.len_err || desc_keep_err != e.keep_err || desc_csum !== e.csum) begin
            n_fail++;
            $display("FAIL desc[%0d]: got bytes=%0d beats=%0d len=%0b keep=%0b csum=%08h expected bytes=%0d beats=%0d len=%0b keep=%0b csum=%08h",
                     n_desc, desc_byte_cnt, desc_beat_cnt, desc_len_err, desc_keep_err, desc_csum,
                     e.bytes, e.beats, e.len_err, e.keep_err, e.csum);
          end
        end
        n_desc++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int            highs;
    logic [KW-1:0] k_mid;
    logic [KW-1:0] k_last;
    logic [DW-1:0] d0, d1, d2;

    // Reset behaviour
    repeat (3) @(negedge axis_clk);
    #1;
    check("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    check("rst_desc_valid", {63'd0, desc_valid}, 64'd0);
    @(negedge axis_clk);
    axis_rst = 1'b0;
    #1;
    check("post_rst_desc", {desc_byte_cnt, desc_beat_cnt, desc_csum}, 64'd0);
    check("post_rst_flags", {62'd0, desc_len_err, desc_keep_err}, 64'd0);
    check("post_rst_cnts", {pkt_cnt, err_cnt}, 64'd0);
    @(negedge axis_clk);

    // Single full beat, tuser_size=64
    clear_pk();
    add_beat(rand_data(), {KW{1'b1}}, 16'd64);
    send_pkt();
    check("single_desc_valid", {63'd0, desc_valid}, 64'd1);
    check("single_pkt_cnt", 64'(pkt_cnt), 64'd1);
    wait_drain();

    // 130-byte, 3-beat packet: clean, then wrong size, then bad middle keep
    d0 = rand_data(); d1 = rand_data(); d2 = rand_data();
    k_last = ones_keep(2);
    clear_pk();
    add_beat(d0, {KW{1'b1}}, 16'd130); add_beat(d1, {KW{1'b1}}, 16'd130); add_beat(d2, k_last, 16'd130);
    send_pkt();
    clear_pk();
    add_beat(d0, {KW{1'b1}}, 16'd100); add_beat(d1, {KW{1'b1}}, 16'd100); add_beat(d2, k_last, 16'd100);
    send_pkt();
    wait_drain();
    k_mid = {4'h0, {(KW - 4){1'b1}}};
    clear_pk();
    add_beat(d0, {KW{1'b1}}, 16'd126); add_beat(d1, k_mid, 16'd126); add_beat(d2, k_last, 16'd126);
    send_pkt();
    wait_drain();

    // FIFO full: 8 held, 9th stalls until the consumer resumes
    desc_ready = 1'b0;
    for (int p = 0; p < 8; p++) begin
      clear_pk();
      add_beat(rand_data(), {KW{1'b1}}, 16'd64);
      send_pkt();
    end
    #1;
    check("full_tready", {63'd0, s_axis_tready}, 64'd0);
    check("full_desc_valid", {63'd0, desc_valid}, 64'd1);
    @(negedge axis_clk);
    clear_pk();
    add_beat(rand_data(), ones_keep(7), 16'd7);
    fork
      send_pkt();
      begin
        repeat (10) @(negedge axis_clk);
        #1;
        check("full_stall_tready", {63'd0, s_axis_tready}, 64'd0);
        check("full_stall_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt - 1));
        desc_ready = 1'b1;
      end
    join
    wait_drain();

    // Alternating backpressure
    bp_pattern = 16'h5555;
    highs = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge axis_clk); #1;
      if (s_axis_tready) highs++;
    end
    check("bp5555_ready_highs", 64'(highs), 64'd8);
    @(negedge axis_clk);
    for (int p = 0; p < 4; p++) begin
      build_random();
      send_pkt();
    end
    wait_drain();

    // Random traffic, random throttling and consumer stalls
    rand_ready_en = 1'b1;
    for (int p = 0; p < 24; p++) begin
      bp_pattern = 16'($urandom_range(1, 65535));
      build_random();
      send_pkt();
      repeat ($urandom_range(0, 2)) @(negedge axis_clk);
    end
    rand_ready_en = 1'b0;
    @(negedge axis_clk);
    desc_ready = 1'b1;
    bp_pattern = 16'hFFFF;
    wait_drain();

    // Reset in the middle of a packet
    clear_pk();
    add_beat(rand_data(), {KW{1'b1}}, 16'd150);
    add_beat(rand_data(), {KW{1'b1}}, 16'd150);
    add_beat(rand_data(), ones_keep(22), 16'd150);
    send_beat(0);
    send_beat(1);
    axis_rst = 1'b1;
    #1;
    check("midrst_tready", {63'd0, s_axis_tready}, 64'd0);
    repeat (2) @(negedge axis_clk);
    #1;
    check("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("midrst_desc_valid", {63'd0, desc_valid}, 64'd0);
    exp_pkt = 0;
    exp_err = 0;
    @(negedge axis_clk);
    axis_rst = 1'b0;
    @(negedge axis_clk);
    clear_pk();
    add_beat(rand_data(), {KW{1'b1}}, 16'd80);
    add_beat(rand_data(), ones_keep(16), 16'd80);
    send_pkt();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
